// File: rtl/stream_demux_1ton_if.sv
// Stream demux bundle: one producer-side valid/ready port fanning out to NUM_OUT lanes,
// plus the drop status. The slave modport is the demux; the master modport is its surroundings.
interface stream_demux_1ton_if #(
   parameter int unsigned WIDTH   = 8,
   parameter int unsigned NUM_OUT = 4,
   parameter int unsigned SEL_W   = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1
);
   logic [WIDTH-1:0]         in_data;
   logic [SEL_W-1:0]         in_sel;
   logic                     in_valid;
   logic                     in_ready;
   logic [NUM_OUT*WIDTH-1:0] out_data;
   logic [NUM_OUT-1:0]       out_valid;
   logic [NUM_OUT-1:0]       out_ready;
   logic                     err_sel;
   logic [7:0]               drop_cnt;

   modport master (
      output in_data, in_sel, in_valid, out_ready,
      input  in_ready, out_data, out_valid, err_sel, drop_cnt
   );

   modport slave (
      input  in_data, in_sel, in_valid, out_ready,
      output in_ready, out_data, out_valid, err_sel, drop_cnt
   );
endinterface

// File: rtl/stream_demux_1ton.sv
// Registered 1-to-N stream demultiplexer with a single-entry holding stage.
// Words with an out-of-range select are consumed, flagged and counted.
module stream_demux_1ton #(
   parameter int unsigned WIDTH   = 8,
   parameter int unsigned NUM_OUT = 4,
   parameter int unsigned SEL_W   = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1
) (
   input  logic                clk,
   input  logic                rst_n,
   stream_demux_1ton_if.slave  bus
);

   localparam int unsigned DW = NUM_OUT * WIDTH;

   typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

   state_t             state_q,     state_n;
   logic [SEL_W-1:0]   hold_sel_q,  hold_sel_n;
   logic [NUM_OUT-1:0] out_valid_q, out_valid_n;
   logic [DW-1:0]      out_data_q,  out_data_n;
   logic               err_sel_q,   err_sel_n;
   logic [7:0]         drop_cnt_q,  drop_cnt_n;

   logic [NUM_OUT-1:0] in_onehot;
   logic [NUM_OUT-1:0] hold_onehot;
   logic [DW-1:0]      load_data;
   logic               sel_legal;
   logic               in_ready_c;
   logic               in_fire;
   logic               out_fire;
   logic               load;
   logic               drop;

   // Select decode; an in_sel matching no lane is the illegal case.
   always_comb begin
      in_onehot   = '0;
      hold_onehot = '0;
      load_data   = '0;
      for (int unsigned k = 0; k < NUM_OUT; k++) begin
         if (bus.in_sel == SEL_W'(k)) begin
            in_onehot[k]                = 1'b1;
            load_data[k*WIDTH +: WIDTH] = bus.in_data;
         end
         if (hold_sel_q == SEL_W'(k)) hold_onehot[k] = 1'b1;
      end
   end

   // Ready depends only on the held lane's consumer, never on in_valid.
   always_comb begin
      sel_legal  = |in_onehot;
      out_fire   = (state_q == FULL) && (|(bus.out_ready & hold_onehot));
      in_ready_c = (state_q == EMPTY) || out_fire;
      in_fire    = bus.in_valid && in_ready_c;
      load       = in_fire && sel_legal;
      drop       = in_fire && !sel_legal;
   end

   always_comb begin
      state_n     = state_q;
      hold_sel_n  = hold_sel_q;
      out_valid_n = out_valid_q;
      out_data_n  = out_data_q;
      err_sel_n   = drop;
      drop_cnt_n  = drop_cnt_q;

      if (drop && (drop_cnt_q != 8'hFF)) drop_cnt_n = drop_cnt_q + 8'd1;

      case (state_q)
         EMPTY:   if (load) state_n = FULL;
         FULL:    if (!load && out_fire) state_n = EMPTY;
         default: state_n = EMPTY;
      endcase

      // A reload in the same cycle as out_fire replaces the word with no bubble.
      if (load) begin
         hold_sel_n  = bus.in_sel;
         out_valid_n = in_onehot;
         out_data_n  = load_data;
      end else if (out_fire) begin
         out_valid_n = '0;
         out_data_n  = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= EMPTY;
         hold_sel_q  <= '0;
         out_valid_q <= '0;
         out_data_q  <= '0;
         err_sel_q   <= 1'b0;
         drop_cnt_q  <= '0;
      end else begin
         state_q     <= state_n;
         hold_sel_q  <= hold_sel_n;
         out_valid_q <= out_valid_n;
         out_data_q  <= out_data_n;
         err_sel_q   <= err_sel_n;
         drop_cnt_q  <= drop_cnt_n;
      end
   end

   assign bus.in_ready  = in_ready_c;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.err_sel   = err_sel_q;
   assign bus.drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_stream_demux_1ton.sv
// Bench for stream_demux_1ton: a 4-lane instance for the main traffic cases and a 3-lane
// instance where select value 3 is out of range, both checked every cycle against a model.
module tb_stream_demux_1ton;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   stream_demux_1ton_if #(.WIDTH(8), .NUM_OUT(4)) if4 ();
   stream_demux_1ton_if #(.WIDTH(8), .NUM_OUT(3)) if3 ();

   stream_demux_1ton #(.WIDTH(8), .NUM_OUT(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(if4.slave));
   stream_demux_1ton #(.WIDTH(8), .NUM_OUT(3)) u_dut3 (.clk(clk), .rst_n(rst_n), .bus(if3.slave));

   // Index 0 drives/observes the 4-lane DUT, index 1 the 3-lane DUT.
   logic [7:0]  d  [2];
   logic [1:0]  s  [2];
   logic        v  [2];
   logic [3:0]  r  [2];
   logic [3:0]  ov [2];
   logic [31:0] od [2];
   logic        ir [2];
   logic        es [2];
   logic [7:0]  dc [2];

   assign if4.in_data   = d[0];
   assign if4.in_sel    = s[0];
   assign if4.in_valid  = v[0];
   assign if4.out_ready = r[0];
   assign if3.in_data   = d[1];
   assign if3.in_sel    = s[1];
   assign if3.in_valid  = v[1];
   assign if3.out_ready = r[1][2:0];

   assign ov[0] = if4.out_valid;
   assign od[0] = if4.out_data;
   assign ir[0] = if4.in_ready;
   assign es[0] = if4.err_sel;
   assign dc[0] = if4.drop_cnt;
   assign ov[1] = {1'b0, if3.out_valid};
   assign od[1] = {8'h00, if3.out_data};
   assign ir[1] = if3.in_ready;
   assign es[1] = if3.err_sel;
   assign dc[1] = if3.drop_cnt;

   int unsigned n_chk  = 0;
   int unsigned n_pass = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   // Reference model: at most one pending word per DUT, described by the spec's rules.
   bit          pend     [2];
   logic [7:0]  pend_dat [2];
   int unsigned pend_ln  [2];
   int unsigned drops    [2];
   bit          dropped  [2];

   function automatic int unsigned lanes(input int k);
      return (k == 0) ? 4 : 3;
   endfunction

   function automatic logic [3:0] exp_ov(input int k);
      return pend[k] ? 4'(1 << pend_ln[k]) : 4'h0;
   endfunction

   function automatic logic [31:0] exp_od(input int k);
      return pend[k] ? (32'(pend_dat[k]) << (8 * pend_ln[k])) : 32'h0;
   endfunction

   function automatic logic exp_ir(input int k);
      return !pend[k] || r[k][pend_ln[k]];
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         pend[k]     = 1'b0;
         pend_dat[k] = 8'h00;
         pend_ln[k]  = 0;
         drops[k]    = 0;
         dropped[k]  = 1'b0;
      end
   endtask

   task automatic model_step();
      for (int k = 0; k < 2; k++) begin
         bit acc, legal, taken;
         acc        = v[k] && exp_ir(k);
         taken      = pend[k] && r[k][pend_ln[k]];
         legal      = 32'(s[k]) < lanes(k);
         dropped[k] = acc && !legal;
         if (dropped[k] && drops[k] < 255) drops[k]++;
         if (acc && legal) begin
            pend[k]     = 1'b1;
            pend_dat[k] = d[k];
            pend_ln[k]  = 32'(s[k]);
         end else if (taken) begin
            pend[k] = 1'b0;
         end
      end
   endtask

   task automatic check_model();
      for (int k = 0; k < 2; k++) begin
         chk($sformatf("dut%0d out_valid", k), 32'(ov[k]), 32'(exp_ov(k)));
         chk($sformatf("dut%0d out_data", k),  od[k],      exp_od(k));
         chk($sformatf("dut%0d in_ready", k),  32'(ir[k]), 32'(exp_ir(k)));
         chk($sformatf("dut%0d err_sel", k),   32'(es[k]), 32'(dropped[k]));
         chk($sformatf("dut%0d drop_cnt", k),  32'(dc[k]), drops[k]);
      end
   endtask

   task automatic settle();
      @(negedge clk);
      check_model();
   endtask

   task automatic advance();
      @(posedge clk);
      if (rst_n) model_step();
      #1;
   endtask

   task automatic idle_all();
      for (int k = 0; k < 2; k++) begin
         d[k] = 8'h00; s[k] = 2'd0; v[k] = 1'b0; r[k] = 4'hF;
      end
   endtask

   typedef struct {
      logic [7:0]  d;
      logic [1:0]  s;
      logic        v;
      logic [3:0]  r;
      logic [3:0]  ov;
      logic [31:0] od;
      logic        ir;
   } vec_t;

   vec_t tbl [16];

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Single transfer, backpressure with a waiting word, streaming, ready on the wrong lane.
      tbl[0]  = '{8'hA5, 2'd2, 1'b1, 4'hF, 4'h0, 32'h0000_0000, 1'b1};
      tbl[1]  = '{8'h00, 2'd0, 1'b0, 4'hF, 4'h4, 32'h00A5_0000, 1'b1};
      tbl[2]  = '{8'h00, 2'd0, 1'b0, 4'hF, 4'h0, 32'h0000_0000, 1'b1};
      tbl[3]  = '{8'h3C, 2'd1, 1'b1, 4'h0, 4'h0, 32'h0000_0000, 1'b1};
      tbl[4]  = '{8'h77, 2'd0, 1'b1, 4'h0, 4'h2, 32'h0000_3C00, 1'b0};
      tbl[5]  = '{8'h77, 2'd0, 1'b1, 4'h0, 4'h2, 32'h0000_3C00, 1'b0};
      tbl[6]  = '{8'h77, 2'd0, 1'b1, 4'h0, 4'h2, 32'h0000_3C00, 1'b0};
      tbl[7]  = '{8'h77, 2'd0, 1'b1, 4'h2, 4'h2, 32'h0000_3C00, 1'b1};
      tbl[8]  = '{8'h00, 2'd0, 1'b0, 4'hF, 4'h1, 32'h0000_0077, 1'b1};
      tbl[9]  = '{8'h11, 2'd0, 1'b1, 4'hF, 4'h0, 32'h0000_0000, 1'b1};
      tbl[10] = '{8'h22, 2'd1, 1'b1, 4'hF, 4'h1, 32'h0000_0011, 1'b1};
      tbl[11] = '{8'h33, 2'd2, 1'b1, 4'hF, 4'h2, 32'h0000_2200, 1'b1};
      tbl[12] = '{8'h44, 2'd3, 1'b1, 4'hF, 4'h4, 32'h0033_0000, 1'b1};
      tbl[13] = '{8'h00, 2'd0, 1'b0, 4'h7, 4'h8, 32'h4400_0000, 1'b0};
      tbl[14] = '{8'h00, 2'd0, 1'b0, 4'hF, 4'h8, 32'h4400_0000, 1'b1};
      tbl[15] = '{8'h00, 2'd0, 1'b0, 4'hF, 4'h0, 32'h0000_0000, 1'b1};

      idle_all();
      model_reset();
      rst_n = 1'b0;
      #1;
      // Reset held for two cycles under random input activity.
      for (int i = 0; i < 2; i++) begin
         for (int k = 0; k < 2; k++) begin
            d[k] = 8'($urandom); s[k] = 2'($urandom); v[k] = 1'($urandom); r[k] = 4'($urandom);
         end
         settle();
         advance();
      end
      idle_all();
      rst_n = 1'b1;
      settle();
      chk("in_ready after reset release", 32'(ir[0]), 32'd1);
      advance();

      for (int i = 0; i < 16; i++) begin
         d[0] = tbl[i].d; s[0] = tbl[i].s; v[0] = tbl[i].v; r[0] = tbl[i].r;
         settle();
         chk($sformatf("vec%0d out_valid", i), 32'(ov[0]), 32'(tbl[i].ov));
         chk($sformatf("vec%0d out_data", i),  od[0],      tbl[i].od);
         chk($sformatf("vec%0d in_ready", i),  32'(ir[0]), 32'(tbl[i].ir));
         advance();
      end
      idle_all();

      // Out-of-range select on the 3-lane instance, then saturation of the drop counter.
      d[1] = 8'hFF; s[1] = 2'd3; v[1] = 1'b1;
      settle();
      advance();
      v[1] = 1'b0;
      settle();
      chk("illegal err_sel pulse", 32'(es[1]), 32'd1);
      chk("illegal drop_cnt=1",    32'(dc[1]), 32'd1);
      chk("illegal out_valid",     32'(ov[1]), 32'd0);
      advance();
      settle();
      chk("illegal err_sel one cycle", 32'(es[1]), 32'd0);
      advance();
      for (int i = 0; i < 300; i++) begin
         d[1] = 8'($urandom); s[1] = 2'd3; v[1] = 1'b1;
         settle();
         advance();
      end
      v[1] = 1'b0;
      settle();
      chk("drop_cnt saturated", 32'(dc[1]), 32'd255);
      advance();

      // Asynchronous reset while lane 2 holds a stalled word.
      d[0] = 8'h5A; s[0] = 2'd2; v[0] = 1'b1; r[0] = 4'h0;
      settle();
      advance();
      v[0] = 1'b0;
      settle();
      chk("stalled lane2 presented", 32'(ov[0]), 32'h4);
      advance();
      #2;
      rst_n = 1'b0;
      #1;
      chk("async reset out_valid", 32'(ov[0]), 32'h0);
      chk("async reset out_data",  od[0],      32'h0);
      model_reset();
      for (int i = 0; i < 2; i++) begin
         settle();
         advance();
      end
      rst_n = 1'b1;
      r[0]  = 4'hF;
      for (int i = 0; i < 3; i++) begin
         settle();
         chk("no re-presentation after reset", 32'(ov[0]), 32'h0);
         advance();
      end

      // Random traffic on both instances, checked against the model every cycle.
      for (int i = 0; i < 2000; i++) begin
         for (int k = 0; k < 2; k++) begin
            v[k] = ($urandom_range(3) != 0);
            s[k] = 2'($urandom);
            d[k] = 8'($urandom);
            r[k] = ($urandom_range(2) == 0) ? 4'($urandom) : 4'hF;
         end
         settle();
         advance();
      end
      idle_all();
      settle();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
